// File: rtl/apb_tick_timer.sv
// APB down-counting tick timer: counts rising edges of the prescaler's tick level,
// flags expiry and raises a maskable level interrupt (one-shot or auto-reload).
module apb_tick_timer #(
  parameter int LOAD_W = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        tick_in,
  output logic        irq
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_LOAD   = 2'd1;
  localparam logic [1:0] A_VALUE  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;
  localparam logic [LOAD_W-1:0] ONE = LOAD_W'(1);

  state_t              r_state, w_state_nxt;
  logic                r_periodic, r_ie, r_expired, r_tick_q;
  logic [LOAD_W-1:0]   r_load, r_value, w_value_nxt;
  logic                w_expired_nxt, w_tick_live;
  logic                w_wr, w_ctrl_wr, w_load_wr, w_status_wr, w_tick_pulse;
  logic [LOAD_W-1:0]   w_wdata_load;
  logic                w_unused;

  assign w_wr         = PSEL & PENABLE & PWRITE;
  assign w_ctrl_wr    = w_wr && (PADDR[3:2] == A_CTRL);
  assign w_load_wr    = w_wr && (PADDR[3:2] == A_LOAD);
  assign w_status_wr  = w_wr && (PADDR[3:2] == A_STATUS);
  assign w_tick_pulse = tick_in & ~r_tick_q;
  assign w_wdata_load = PWDATA[LOAD_W-1:0];
  assign w_unused     = ^{PADDR[1:0], PWDATA};

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign irq     = r_expired & r_ie;

  // Priority: CTRL/LOAD writes pre-empt a same-edge tick; expiry beats W1C.
  always_comb begin
    w_state_nxt   = r_state;
    w_value_nxt   = r_value;
    w_expired_nxt = r_expired;
    w_tick_live   = w_tick_pulse && (r_state == S_RUN);
    if (w_status_wr && PWDATA[0]) w_expired_nxt = 1'b0;
    if (w_ctrl_wr) begin
      if (PWDATA[0] && (r_state == S_IDLE)) begin
        w_state_nxt = S_RUN;
        w_value_nxt = r_load;
        w_tick_live = 1'b0;
      end else if (!PWDATA[0]) begin
        w_state_nxt = S_IDLE;
        w_tick_live = 1'b0;
      end
    end else if (w_load_wr) begin
      w_value_nxt = w_wdata_load;
      w_tick_live = 1'b0;
    end
    if (w_tick_live) begin
      if (r_value != '0) begin
        w_value_nxt = r_value - ONE;
      end else begin
        w_expired_nxt = 1'b1;
        if (r_periodic) w_value_nxt = r_load;
        else            w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state    <= S_IDLE;
      r_periodic <= 1'b0;
      r_ie       <= 1'b0;
      r_expired  <= 1'b0;
      r_tick_q   <= 1'b0;
      r_load     <= '0;
      r_value    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_value   <= w_value_nxt;
      r_expired <= w_expired_nxt;
      r_tick_q  <= tick_in;
      if (w_ctrl_wr) begin
        r_periodic <= PWDATA[1];
        r_ie       <= PWDATA[2];
      end
      if (w_load_wr) r_load <= w_wdata_load;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      case (PADDR[3:2])
        A_CTRL:   PRDATA[2:0] = {r_ie, r_periodic, r_state == S_RUN};
        A_LOAD:   PRDATA[LOAD_W-1:0] = r_load;
        A_VALUE:  PRDATA[LOAD_W-1:0] = r_value;
        A_STATUS: PRDATA[0] = r_expired;
        default:  PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_tick_timer.sv
// Bench for apb_tick_timer: directed scenarios plus random APB/tick traffic
// compared every cycle against an event-level reference model.
module tb_apb_tick_timer;

  logic        PCLK = 1'b0;
  logic        PRESETn, PSEL, PENABLE, PWRITE, tick_in;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR, irq;

  apb_tick_timer #(.LOAD_W(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .tick_in(tick_in), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  int n_chk = 0, n_bad = 0;
  logic [31:0] last_rd;

  // reference model state
  bit m_en, m_per, m_ie, m_exp, m_tq;
  int unsigned m_load, m_val;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {29'd0, m_ie, m_per, m_en};
      2'd1:    return m_load;
      2'd2:    return m_val;
      default: return {31'd0, m_exp};
    endcase
  endfunction

  // Apply what the block should do at one clock edge with the current inputs.
  task automatic model_edge();
    bit pulse, wr, live, old_per;
    int a;
    if (!PRESETn) begin
      m_en = 0; m_per = 0; m_ie = 0; m_exp = 0; m_tq = 0; m_load = 0; m_val = 0;
      return;
    end
    pulse   = tick_in && !m_tq;
    m_tq    = tick_in;
    wr      = PSEL && PENABLE && PWRITE;
    a       = int'(PADDR[3:2]);
    live    = m_en && pulse;
    old_per = m_per;
    if (wr && a == 3 && PWDATA[0]) m_exp = 0;
    if (wr && a == 0) begin
      m_per = PWDATA[1];
      m_ie  = PWDATA[2];
      if (PWDATA[0] && !m_en) begin m_en = 1; m_val = m_load; live = 0; end
      else if (!PWDATA[0])    begin m_en = 0; live = 0; end
    end else if (wr && a == 1) begin
      m_load = PWDATA & 32'hFFFF;
      m_val  = m_load;
      live   = 0;
    end
    if (live) begin
      if (m_val > 0) m_val = m_val - 1;
      else begin
        m_exp = 1;
        if (old_per) m_val = m_load;
        else         m_en  = 0;
      end
    end
  endtask

  // One clock: check combinational outputs mid-cycle, then advance model at the edge.
  task automatic cycle();
    #1;
    chk("prdata", PRDATA, PSEL ? m_rd(PADDR) : 32'd0);
    chk("irq", {31'd0, irq}, {31'd0, m_exp & m_ie});
    last_rd = PRDATA;
    @(posedge PCLK);
    model_edge();
    #1;
  endtask

  task automatic idle_bus();
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic rst(input int n);
    idle_bus();
    PRESETn = 0;
    repeat (n) cycle();
    PRESETn = 1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic t);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
    cycle();
    PENABLE = 1; tick_in = t;
    cycle();
    idle_bus();
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
    cycle();
    PENABLE = 1;
    cycle();
    d = last_rd;
    idle_bus();
  endtask

  task automatic pulse();
    tick_in = 1; cycle();
    tick_in = 0; cycle();
  endtask

  logic [31:0] d;
  int exp_v[9] = '{1, 0, 2, 1, 0, 2, 1, 0, 2};

  initial begin
    PRESETn = 0; tick_in = 0; PADDR = 0; PWDATA = 0;
    idle_bus();
    @(posedge PCLK); #1;

    // reset
    rst(3);
    for (int i = 0; i < 4; i++) begin
      rd(4'(i * 4), d);
      chk("rst_reg", d, 32'd0);
    end
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_pready", {31'd0, PREADY}, 32'd1);
    chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);

    // one-shot
    wr(4'h4, 3, 0);
    wr(4'h0, 32'h5, 0);
    for (int i = 0; i < 4; i++) begin
      pulse();
      rd(4'h8, d);
      chk("os_val", d, (i < 2) ? 32'(2 - i) : 32'd0);
    end
    rd(4'hC, d);            chk("os_exp", d, 32'd1);
    chk("os_irq", {31'd0, irq}, 32'd1);
    rd(4'h0, d);            chk("os_ctrl", d, 32'h4);
    pulse();
    rd(4'h8, d);            chk("os_val5", d, 32'd0);

    // periodic, ie=0
    rst(1);
    wr(4'h4, 2, 0);
    wr(4'h0, 32'h3, 0);
    for (int i = 1; i <= 9; i++) begin
      pulse();
      rd(4'h8, d);          chk("per_val", d, 32'(exp_v[i-1]));
      rd(4'hC, d);          chk("per_exp", d, (i % 3 == 0) ? 32'd1 : 32'd0);
      chk("per_irq", {31'd0, irq}, 32'd0);
      if (d[0]) wr(4'hC, 1, 0);
    end

    // W1C race against expiry
    rst(2);
    wr(4'h4, 0, 0);
    wr(4'h0, 32'h7, 0);
    pulse();
    rd(4'hC, d);            chk("w1c_pre", d, 32'd1);
    wr(4'hC, 1, 1);
    tick_in = 0; cycle();
    rd(4'hC, d);            chk("w1c_race", d, 32'd1);
    chk("w1c_race_irq", {31'd0, irq}, 32'd1);
    wr(4'hC, 1, 0);
    rd(4'hC, d);            chk("w1c_clr", d, 32'd0);
    chk("w1c_clr_irq", {31'd0, irq}, 32'd0);

    // held tick level counts once
    rst(1);
    wr(4'h4, 10, 0);
    wr(4'h0, 32'h1, 0);
    tick_in = 1;
    repeat (50) cycle();
    tick_in = 0; cycle();
    rd(4'h8, d);            chk("edge_val", d, 32'd9);

    // LOAD write racing a tick, then mid-count reset
    rst(1);
    wr(4'h4, 8, 0);
    wr(4'h0, 32'h1, 0);
    repeat (3) pulse();
    rd(4'h8, d);            chk("mid_val5", d, 32'd5);
    wr(4'h4, 20, 1);
    tick_in = 0; cycle();
    rd(4'h8, d);            chk("load_race", d, 32'd20);
    rst(1);
    for (int i = 0; i < 4; i++) begin
      rd(4'(i * 4), d);
      chk("mid_rst_reg", d, 32'd0);
    end
    repeat (2) pulse();
    rd(4'h8, d);            chk("mid_rst_val", d, 32'd0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst($urandom_range(1, 2));
      end else begin
        PSEL    = $urandom_range(0, 1) == 1;
        PENABLE = $urandom_range(0, 1) == 1;
        PWRITE  = $urandom_range(0, 1) == 1;
        PADDR   = 4'($urandom);
        PWDATA  = $urandom;
        if (PADDR[3:2] == 2'd1 && $urandom_range(0, 3) != 0) PWDATA = $urandom_range(0, 5);
        if (PADDR[3:2] == 2'd0) PWDATA[0] = $urandom_range(0, 3) != 0;
        if ($urandom_range(0, 9) < 4) tick_in = ~tick_in;
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
